// File: rtl/div47_seq.sv
// Sequential divide-by-47 of a 60-bit dividend, one 6-bit digit per cycle; result 10 edges after accept.
// Single job in flight: in_ready only when idle, result held until out_ready. DIV47_REM_OUT_EN adds the remainder port.
module div47_seq (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [59:0] dividend,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [54:0] quotient
`ifdef DIV47_REM_OUT_EN
  ,
  output logic [5:0]  remainder
`endif
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t      state;
  state_t      state_nxt;
  logic [59:0] dreg;
  logic [5:0]  r;
  logic [3:0]  cnt;
  logic [59:0] qreg;

  logic [11:0] t;
  logic [11:0] acc;
  logic [5:0]  d;
  logic [5:0]  r_nxt;
  logic [4:0]  qreg_unused;

  // t < 64*47, so six shifted compare/subtract steps yield the full digit
  always_comb begin
    t   = {r, dreg[59:54]};
    acc = t;
    d   = 6'd0;
    for (int i = 5; i >= 0; i--) begin
      if (acc >= (12'd47 << i)) begin
        acc  = acc - (12'd47 << i);
        d[i] = 1'b1;
      end
    end
    r_nxt = acc[5:0];
  end

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_nxt = RUN;
      end
      RUN: begin
        if (cnt == 4'd9) state_nxt = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      dreg  <= 60'd0;
      r     <= 6'd0;
      cnt   <= 4'd0;
      qreg  <= 60'd0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: begin
          if (in_valid) begin
            dreg <= dividend;
            r    <= 6'd0;
            cnt  <= 4'd0;
            qreg <= 60'd0;
          end
        end
        RUN: begin
          dreg <= {dreg[53:0], 6'd0};
          r    <= r_nxt;
          cnt  <= cnt + 4'd1;
          qreg <= {qreg[53:0], d};
        end
        default: ;
      endcase
    end
  end

  // The leading digit is floor(c/47) <= 1, so the top five quotient bits never get set
  assign qreg_unused = qreg[59:55];
  assign quotient    = qreg[54:0];

`ifdef DIV47_REM_OUT_EN
  assign remainder = r;
`endif

endmodule

// File: tb/tb_div47_seq.sv
// Directed and randomised checks of div47_seq, including stall, reset-mid-run and latency.
module tb_div47_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [59:0] dividend;
  logic        out_valid;
  logic        out_ready;
  logic [54:0] quotient;
  logic [5:0]  rem_obs;

  int n_tests = 0;
  int n_fail  = 0;

`ifdef DIV47_REM_OUT_EN
  logic [5:0] remainder;
  assign rem_obs = remainder;
`else
  assign rem_obs = dut.r;
`endif

  div47_seq dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .dividend  (dividend),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .quotient  (quotient)
`ifdef DIV47_REM_OUT_EN
    ,
    .remainder (remainder)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Called one tick after an edge with the DUT idle; returns one tick after DONE->IDLE.
  task automatic run_one(input logic [59:0] a, input logic [63:0] eq, input logic [63:0] er,
                         input int stall, input string tag);
    int lat;
    logic [63:0] junk;
    check({tag, " in_ready_idle"}, {63'd0, in_ready}, 64'd1);
    in_valid = 1'b1;
    dividend = a;
    step();
    in_valid = 1'b0;
    dividend = ~a;
    lat = 0;
    while (!out_valid && lat < 20) begin
      step();
      lat++;
    end
    check({tag, " latency"}, 64'(lat), 64'd10);
    check({tag, " quotient"}, {9'd0, quotient}, eq);
    check({tag, " remainder"}, {58'd0, rem_obs}, er);
    check({tag, " qreg_top"}, {59'd0, dut.qreg[59:55]}, 64'd0);
    for (int i = 0; i < stall; i++) begin
      junk     = {$urandom(), $urandom()};
      in_valid = 1'b1;
      dividend = junk[59:0];
      step();
      check({tag, " stall_quotient"}, {9'd0, quotient}, eq);
      check({tag, " stall_remainder"}, {58'd0, rem_obs}, er);
      check({tag, " stall_valid"}, {63'd0, out_valid}, 64'd1);
      check({tag, " stall_in_ready"}, {63'd0, in_ready}, 64'd0);
    end
    // in_valid stays high on the release edge; it must not start a new job
    in_valid  = 1'b1;
    out_ready = 1'b1;
    step();
    in_valid  = 1'b0;
    out_ready = 1'b0;
    check({tag, " released_valid"}, {63'd0, out_valid}, 64'd0);
    check({tag, " released_in_ready"}, {63'd0, in_ready}, 64'd1);
    step();
    check({tag, " not_restarted"}, {63'd0, in_ready}, 64'd1);
  endtask

  initial begin
    logic [63:0] rv;
    logic [59:0] a;
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    dividend  = 60'd0;
    step();
    step();
    rst = 1'b0;
    check("reset in_ready", {63'd0, in_ready}, 64'd1);
    check("reset out_valid", {63'd0, out_valid}, 64'd0);
    check("reset quotient", {9'd0, quotient}, 64'd0);
    check("reset remainder", {58'd0, rem_obs}, 64'd0);

    run_one(60'd0, 64'd0, 64'd0, 0, "zero");
    run_one(60'd47, 64'd1, 64'd0, 0, "d47");
    run_one(60'd1000, 64'd21, 64'd13, 0, "d1000");
    run_one(60'hFFF_FFFF_FFFF_FFFF, 64'd24530244778869084, 64'd27, 0, "max");
    run_one(60'd1000, 64'd21, 64'd13, 7, "stall");
    run_one(60'd94, 64'd2, 64'd0, 0, "after_stall");

    // Reset in the middle of a job, with out_ready toggling outside DONE
    in_valid = 1'b1;
    dividend = 60'd1000;
    step();
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (5) step();
    out_ready = 1'b0;
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("midrst in_ready", {63'd0, in_ready}, 64'd1);
    check("midrst out_valid", {63'd0, out_valid}, 64'd0);
    check("midrst quotient", {9'd0, quotient}, 64'd0);
    check("midrst remainder", {58'd0, rem_obs}, 64'd0);
    run_one(60'd48, 64'd1, 64'd1, 0, "post_rst");

    for (int k = 0; k < 200; k++) begin
      rv = {$urandom(), $urandom()};
      a  = rv[59:0];
      run_one(a, {4'd0, a} / 64'd47, {4'd0, a} % 64'd47, int'($urandom_range(0, 3)), "rand");
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
